// File: rtl/tt_um_sequential_divider_4bit.sv
// tt_um_sequential_divider_4bit: restoring divider, one quotient bit per clock, flags divide-by-zero
module tt_um_sequential_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    input  logic       in_valid,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       out_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t           r_state, w_state_nx;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_rem, r_shift, r_div, r_q, r_r;
    logic             r_dbz;
    logic [WIDTH-1:0] w_a, w_b, w_rem_nx, w_shift_nx;
    logic [WIDTH:0]   w_shifted, w_trial;
    logic             w_qbit, w_last, w_start, w_unused;

    assign w_a        = ui_in[WIDTH-1:0];
    assign w_b        = uio_in[WIDTH-1:0];
    assign w_unused   = &{1'b0, ui_in[7:WIDTH], uio_in[7:WIDTH]};
    assign w_start    = (r_state == IDLE) && in_valid;
    assign w_last     = r_cnt == 3'(WIDTH - 1);
    // The trial subtraction is one bit wider than the operands so its msb is the borrow.
    assign w_shifted  = {r_rem, r_shift[WIDTH-1]};
    assign w_trial    = w_shifted - {1'b0, r_div};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_nx   = w_qbit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_shift_nx = (r_shift << 1) | WIDTH'(w_qbit);

    assign uo_out   = {4'(r_r), 4'(r_q)};
    assign uio_out  = {2'b00, r_state == CALC, r_dbz, 4'b0000};
    assign uio_oe   = 8'h30;
    assign out_done = r_state == DONE;

    always_comb begin
        w_state_nx = IDLE;
        if (r_state == IDLE) begin
            if (in_valid && w_b == '0) w_state_nx = DONE;
            else if (in_valid)         w_state_nx = CALC;
            else                       w_state_nx = IDLE;
        end else if (r_state == CALC) begin
            if (w_last) w_state_nx = DONE;
            else        w_state_nx = CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else if (w_start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_shift <= w_a;
            r_div   <= w_b;
            if (w_b == '0) begin
                r_q   <= '1;
                r_r   <= w_a;
                r_dbz <= 1'b1;
            end
        end else if (r_state == CALC) begin
            r_cnt   <= r_cnt + 3'd1;
            r_rem   <= w_rem_nx;
            r_shift <= w_shift_nx;
            if (w_last) begin
                r_q   <= w_shift_nx;
                r_r   <= w_rem_nx;
                r_dbz <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tt_um_sequential_divider_4bit.sv
// tb_tt_um_sequential_divider_4bit: vector table, corner sequences and full operand sweep with a result scoreboard
module tb_tt_um_sequential_divider_4bit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic       in_valid = 1'b0;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic       out_done;

    typedef struct packed {logic [7:0] uo; logic dbz;} exp_t;
    typedef struct {logic [7:0] a; logic [7:0] b; logic [7:0] uo; logic dbz;} vec_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    logic [7:0] last_uo = 8'h00;

    tt_um_sequential_divider_4bit dut (
        .clk(clk), .reset(reset), .ui_in(ui_in), .uio_in(uio_in), .in_valid(in_valid),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .out_done(out_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_uo(input logic [3:0] a, input logic [3:0] b);
        return (b == 4'd0) ? {a, 4'hF} : {a % b, a / b};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_uo_out", uo_out, e.uo);
                chk("sb_uio_out", uio_out, e.dbz ? 8'h10 : 8'h00);
                chk("sb_uio_oe", uio_oe, 8'h30);
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_uo, input logic exp_dbz);
        int  n;
        bit  got;
        @(posedge clk); #1;
        ui_in = a; uio_in = b; in_valid = 1'b1;
        sb.push_back({exp_uo, exp_dbz});
        @(posedge clk); #1;
        in_valid = 1'b0; ui_in = 8'($urandom); uio_in = 8'($urandom);
        n = 0; got = 0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (out_done) got = 1;
            else if (b[3:0] != 4'd0) begin
                chk("busy_calc", uio_out[5], 1);
                chk("hold_calc", uo_out, last_uo);
            end
        end
        chk("done_seen", got, 1);
        chk("latency", n, (b[3:0] == 4'd0) ? 1 : 5);
        last_uo = exp_uo;
        @(negedge clk);
        chk("done_pulse", out_done, 0);
        chk("hold_idle", uo_out, exp_uo);
    endtask

    initial begin
        vec_t vecs[8];
        int   base;
        vecs[0] = '{8'h0D, 8'h03, 8'h14, 1'b0};
        vecs[1] = '{8'h0F, 8'h01, 8'h0F, 1'b0};
        vecs[2] = '{8'h03, 8'h07, 8'h30, 1'b0};
        vecs[3] = '{8'h00, 8'h05, 8'h00, 1'b0};
        vecs[4] = '{8'h09, 8'h00, 8'h9F, 1'b1};
        vecs[5] = '{8'h08, 8'h02, 8'h04, 1'b0};
        vecs[6] = '{8'hAD, 8'h53, 8'h14, 1'b0};
        vecs[7] = '{8'h5E, 8'hF3, 8'h24, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_done", out_done, 0);
        chk("reset_uio_oe", uio_oe, 8'h30);

        for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].uo, vecs[i].dbz);

        base = done_cnt;
        for (int k = 0; k < 18; k++) begin
            logic [3:0] a, b;
            @(posedge clk); #1;
            a = 4'($urandom);
            b = 4'($urandom_range(1, 15));
            ui_in = {4'($urandom), a}; uio_in = {4'($urandom), b}; in_valid = 1'b1;
            if (k % 6 == 0) begin
                sb.push_back({model_uo(a, b), 1'b0});
                last_uo = model_uo(a, b);
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("stream_done_count", done_cnt - base, 3);
        chk("stream_sb_empty", sb.size(), 0);

        @(posedge clk); #1;
        ui_in = 8'h0E; uio_in = 8'h03; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_uo_out", uo_out, 8'h00);
        chk("abort_uio_out", uio_out, 8'h00);
        chk("abort_done", out_done, 0);
        last_uo = 8'h00;
        repeat (6) @(negedge clk);
        run_op(8'h0E, 8'h03, 8'h24, 1'b0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op({4'($urandom), 4'(a)}, {4'($urandom), 4'(b)}, model_uo(4'(a), 4'(b)), b == 0);

        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tt_um_sequential_divider_4bit.md
Name: tt_um_sequential_divider_4bit

Overview:
- Sequential restoring divider. It is the inverse companion of the team's sequential 4-bit multiplier and uses the same operand/handshake interface (in_valid in, out_done out).
- Accepts a 4-bit dividend and a 4-bit divisor, and produces a 4-bit quotient and a 4-bit remainder, one quotient bit per clock.
- Flags divide-by-zero.
- Sits in the same Tiny Tapeout-style top level as the multiplier: operands on ui_in/uio_in, results on uo_out, status on uio_out.

Parameters:
- WIDTH, 4, operand width. Legal range 1..4, because quotient and remainder must fit together in uo_out.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ui_in  input  8  [WIDTH-1:0] = dividend; upper bits ignored.
- uio_in  input  8  [WIDTH-1:0] = divisor; upper bits ignored.
- in_valid  input  1  start request; sampled only in IDLE.
- uo_out  output  8  [7:4] = remainder, [3:0] = quotient, zero-extended per nibble when WIDTH<4.
- uio_out  output  8  [4] = div_by_zero, [5] = busy; all other bits 0.
- uio_oe  output  8  constant 8'h30 (only bits 5:4 driven).
- out_done  output  1  one-cycle pulse: result on uo_out/uio_out[4] is new and valid.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset has priority over every other action.
  - Reset values: state=IDLE, uo_out=0, uio_out=0, out_done=0, internal registers 0. uio_oe is constant and unaffected by reset.
  - Reset mid-operation aborts the operation. No out_done is issued, and the previous result is cleared to 0.
- States:
  - IDLE: busy=0.
    - in_valid=1 at an edge captures dividend and divisor.
    - divisor!=0: go to CALC, step counter=0, partial remainder=0, shift register=dividend.
    - divisor==0: go to DONE directly, with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - CALC: busy=1. On each edge, one restoring step:
    - trial = {partial_rem[WIDTH-1:0], msb of shift register} minus divisor, computed WIDTH+1 bits wide.
    - trial non-negative: partial_rem=trial[WIDTH-1:0], shift in quotient bit 1.
    - trial negative: partial_rem=shifted value, shift in quotient bit 0.
    - Counter increments each step. On the WIDTH-th step, register the final quotient/remainder into uo_out, set div_by_zero=0, and go to DONE.
  - DONE: busy=0, out_done=1 for exactly this one cycle. Next state is IDLE unconditionally.
- Handshake rules:
  - in_valid is ignored in CALC and DONE. It is not queued.
  - The earliest next acceptance is the edge at the end of the IDLE cycle following DONE.
- Latency, counted from the accepting edge E:
  - Normal: out_done is high in the cycle after edge E+WIDTH (4 cycles for WIDTH=4).
  - Divide-by-zero: out_done is high in the cycle after E.
- Output hold:
  - uo_out and div_by_zero change only on entry to DONE (or on reset).
  - Both hold their value through IDLE and CALC until the next completion.
- Arithmetic: unsigned only. Invariant for divisor!=0: dividend = quotient*divisor + remainder, with remainder < divisor.
- Boundary cases:
  - Dividend 0 gives q=0, r=0.
  - Divisor 1 gives q=dividend, r=0.
  - Divisor > dividend gives q=0, r=dividend.
  - Upper, unused input bits never affect results.

Test Plan:
- Reset, then dividend=13, divisor=3, in_valid pulsed for 1 cycle -> busy=1 for 4 cycles, then out_done=1 for one cycle with uo_out=8'h14 (r=1, q=4) and div_by_zero=0. out_done must be 0 in all other cycles.
- 15/1 -> uo_out=8'h0F. 3/7 -> uo_out=8'h30. 0/5 -> uo_out=8'h00. Each result must be held stable after out_done until the next completion.
- 9/0 -> out_done in the cycle after acceptance, uo_out=8'h9F, uio_out[4]=1. A following 8/2 must clear the flag and give uo_out=8'h04.
- Hold in_valid=1 continuously with changing operands -> only operands present at IDLE edges are captured. Exactly one out_done per accepted operation, and no operand change during CALC alters the result.
- Assert reset on the 2nd CALC cycle of 14/3 -> next cycle state is IDLE, uo_out=0, uio_out=0, and no out_done. Then 14/3 completes with uo_out=8'h24.
- Exhaustive sweep of all 256 operand pairs, with ui_in[7:4] and uio_in[7:4] randomised -> every result matches the reference model: q=a/b, r=a%b; for b=0, q=15, r=a, flag=1. uio_oe=8'h30 throughout.
